id_stage: RTL and testbench

Instruction-decode stage directly downstream of the fetch stage. Accepts one fetched instruction (PC plus 32-bit RV64I word) per valid/ready handshake, holds it in a single pipeline register, and presents decoded fields (register indices, sign-extended immediate, write-enable, illegal flag) to the execute stage under its own valid/ready handshake. It also supplies the fetch stage's next-PC input: sequential PC+4, or a redirect target on flush.

---
 rtl/id_stage.sv | 130 +++++++++++++
 tb/tb_id_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction-decode pipeline stage: one-entry register between fetch and execute,
// combinational RV64I field/immediate decode, and the fetch stage's next-PC source.
module id_stage #(
  parameter int PC_WIDTH = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IF_valid_i,
  output logic                ID_ready_o,
  input  logic [PC_WIDTH-1:0] IF_pc_i,
  input  logic [31:0]         IF_instr_i,
  input  logic                flush_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic [PC_WIDTH-1:0] pc_next_o,
  output logic                ID_valid_o,
  input  logic                EX_ready_i,
  output logic [PC_WIDTH-1:0] ID_pc_o,
  output logic [31:0]         ID_instr_o,
  output logic [6:0]          ID_opcode_o,
  output logic [2:0]          ID_funct3_o,
  output logic [6:0]          ID_funct7_o,
  output logic [4:0]          ID_rd_o,
  output logic [4:0]          ID_rs1_o,
  output logic [4:0]          ID_rs2_o,
  output logic [PC_WIDTH-1:0] ID_imm_o,
  output logic                ID_rf_wen_o,
  output logic                ID_illegal_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic                valid_r;
  logic [PC_WIDTH-1:0] pc_r;
  logic [31:0]         instr_r;
  logic                accept;

  // Handshakes: a beat moves when its valid and the receiver's ready are both
  // high at a rising edge; flush_i vetoes the upstream transfer without
  // touching ready, so the fetch side sees a ready that ignores flush.
  assign ID_ready_o = !valid_r || EX_ready_i;
  assign accept     = IF_valid_i && ID_ready_o && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
      instr_r <= NOP;
    end else if (flush_i) begin
      valid_r <= 1'b0;
    end else if (accept) begin
      valid_r <= 1'b1;
      pc_r    <= IF_pc_i;
      instr_r <= IF_instr_i;
    end else if (EX_ready_i) begin
      valid_r <= 1'b0;
    end
  end

  assign pc_next_o = flush_i ? redirect_pc_i : IF_pc_i + PC_WIDTH'(4);

  assign ID_valid_o  = valid_r;
  assign ID_pc_o     = pc_r;
  assign ID_instr_o  = instr_r;
  assign ID_opcode_o = instr_r[6:0];
  assign ID_funct3_o = instr_r[14:12];
  assign ID_funct7_o = instr_r[31:25];
  assign ID_rd_o     = instr_r[11:7];
  assign ID_rs1_o    = instr_r[19:15];
  assign ID_rs2_o    = instr_r[24:20];

  logic [6:0] opcode;
  logic       writes_reg;
  logic       known_op;

  assign opcode = instr_r[6:0];

  always_comb begin
    ID_imm_o = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
        ID_imm_o = {{(PC_WIDTH-12){instr_r[31]}}, instr_r[31:20]};
      OP_STORE:
        ID_imm_o = {{(PC_WIDTH-12){instr_r[31]}}, instr_r[31:25], instr_r[11:7]};
      OP_BRANCH:
        ID_imm_o = {{(PC_WIDTH-13){instr_r[31]}}, instr_r[31], instr_r[7],
                    instr_r[30:25], instr_r[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        ID_imm_o = {{(PC_WIDTH-32){instr_r[31]}}, instr_r[31:12], 12'b0};
      OP_JAL:
        ID_imm_o = {{(PC_WIDTH-21){instr_r[31]}}, instr_r[31], instr_r[19:12],
                    instr_r[20], instr_r[30:21], 1'b0};
      default: ID_imm_o = '0;
    endcase
  end

  always_comb begin
    writes_reg = 1'b0;
    known_op   = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG, OP_IMM32, OP_REG32: begin
        writes_reg = 1'b1;
        known_op   = 1'b1;
      end
      OP_BRANCH, OP_STORE, OP_MISC, OP_SYSTEM: known_op = 1'b1;
      default: begin
        writes_reg = 1'b0;
        known_op   = 1'b0;
      end
    endcase
  end

  // Compressed-quadrant encodings (low bits != 11) are not supported here.
  assign ID_illegal_o = (instr_r[1:0] != 2'b11) || !known_op;
  assign ID_rf_wen_o  = writes_reg && !ID_illegal_o && (instr_r[11:7] != 5'd0);

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vectors, stall/flush/reset handling,
// and a handshake scoreboard that checks every consumed beat in order.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_valid_i;
  logic        ID_ready_o;
  logic [63:0] IF_pc_i;
  logic [31:0] IF_instr_i;
  logic        flush_i;
  logic [63:0] redirect_pc_i;
  logic [63:0] pc_next_o;
  logic        ID_valid_o;
  logic        EX_ready_i;
  logic [63:0] ID_pc_o;
  logic [31:0] ID_instr_o;
  logic [6:0]  ID_opcode_o;
  logic [2:0]  ID_funct3_o;
  logic [6:0]  ID_funct7_o;
  logic [4:0]  ID_rd_o;
  logic [4:0]  ID_rs1_o;
  logic [4:0]  ID_rs2_o;
  logic [63:0] ID_imm_o;
  logic        ID_rf_wen_o;
  logic        ID_illegal_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  id_stage #(.PC_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .IF_valid_i(IF_valid_i), .ID_ready_o(ID_ready_o),
    .IF_pc_i(IF_pc_i), .IF_instr_i(IF_instr_i),
    .flush_i(flush_i), .redirect_pc_i(redirect_pc_i), .pc_next_o(pc_next_o),
    .ID_valid_o(ID_valid_o), .EX_ready_i(EX_ready_i),
    .ID_pc_o(ID_pc_o), .ID_instr_o(ID_instr_o),
    .ID_opcode_o(ID_opcode_o), .ID_funct3_o(ID_funct3_o), .ID_funct7_o(ID_funct7_o),
    .ID_rd_o(ID_rd_o), .ID_rs1_o(ID_rs1_o), .ID_rs2_o(ID_rs2_o),
    .ID_imm_o(ID_imm_o), .ID_rf_wen_o(ID_rf_wen_o), .ID_illegal_o(ID_illegal_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge, so at the falling edge they are
  // settled and describe the transfer that the next rising edge will make.
  always @(negedge clk) begin
    if (!rst && ID_valid_o && EX_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", ID_pc_o, 64'hDEAD);
      end else begin
        check("sb_beat_pc", ID_pc_o, exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] instr);
    IF_valid_i = 1'b1;
    IF_pc_i    = pc;
    IF_instr_i = instr;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},   {63'd0, ID_valid_o}, 64'd0);
    check({tag, "_pc"},      ID_pc_o, 64'd0);
    check({tag, "_instr"},   {32'd0, ID_instr_o}, 64'h13);
    check({tag, "_opcode"},  {57'd0, ID_opcode_o}, 64'h13);
    check({tag, "_rd"},      {59'd0, ID_rd_o}, 64'd0);
    check({tag, "_rs1"},     {59'd0, ID_rs1_o}, 64'd0);
    check({tag, "_rs2"},     {59'd0, ID_rs2_o}, 64'd0);
    check({tag, "_funct3"},  {61'd0, ID_funct3_o}, 64'd0);
    check({tag, "_funct7"},  {57'd0, ID_funct7_o}, 64'd0);
    check({tag, "_imm"},     ID_imm_o, 64'd0);
    check({tag, "_rf_wen"},  {63'd0, ID_rf_wen_o}, 64'd0);
    check({tag, "_illegal"}, {63'd0, ID_illegal_o}, 64'd0);
    check({tag, "_ready"},   {63'd0, ID_ready_o}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; IF_valid_i = 1'b0; IF_pc_i = '0; IF_instr_i = '0;
    flush_i = 1'b0; redirect_pc_i = '0; EX_ready_i = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check_reset_values("reset");

    // addi x1,x0,5 then beq / lui back to back with execute always ready
    offer(64'h1000, 32'h0050_0093); exp_q.push_back(64'h1000);
    #1;
    check("addi_pc_next", pc_next_o, 64'h1004);
    cyc();
    check("addi_valid", {63'd0, ID_valid_o}, 64'd1);
    check("addi_pc", ID_pc_o, 64'h1000);
    check("addi_rd", {59'd0, ID_rd_o}, 64'd1);
    check("addi_rs1", {59'd0, ID_rs1_o}, 64'd0);
    check("addi_imm", ID_imm_o, 64'd5);
    check("addi_rf_wen", {63'd0, ID_rf_wen_o}, 64'd1);
    check("addi_illegal", {63'd0, ID_illegal_o}, 64'd0);

    offer(64'h1004, 32'hFE20_8EE3); exp_q.push_back(64'h1004);
    #1;
    check("beq_ready_while_full", {63'd0, ID_ready_o}, 64'd1);
    cyc();
    check("beq_pc", ID_pc_o, 64'h1004);
    check("beq_rs1", {59'd0, ID_rs1_o}, 64'd1);
    check("beq_rs2", {59'd0, ID_rs2_o}, 64'd2);
    check("beq_funct7", {57'd0, ID_funct7_o}, 64'h7F);
    check("beq_imm", ID_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_rf_wen", {63'd0, ID_rf_wen_o}, 64'd0);

    offer(64'h1008, 32'h8000_02B7); exp_q.push_back(64'h1008);
    cyc();
    check("lui_rd", {59'd0, ID_rd_o}, 64'd5);
    check("lui_imm", ID_imm_o, 64'hFFFF_FFFF_8000_0000);
    check("lui_rf_wen", {63'd0, ID_rf_wen_o}, 64'd1);

    // Stall: lui held while addi x3,x0,10 is offered for three cycles
    EX_ready_i = 1'b0;
    offer(64'h100C, 32'h00A0_0193); exp_q.push_back(64'h100C);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", {63'd0, ID_ready_o}, 64'd0);
      check("stall_pc", ID_pc_o, 64'h1008);
      check("stall_instr", {32'd0, ID_instr_o}, 64'h8000_02B7);
      check("stall_valid", {63'd0, ID_valid_o}, 64'd1);
      cyc();
    end
    EX_ready_i = 1'b1;
    cyc();
    check("unstall_pc", ID_pc_o, 64'h100C);
    check("unstall_rd", {59'd0, ID_rd_o}, 64'd3);
    check("unstall_imm", ID_imm_o, 64'd10);
    IF_valid_i = 1'b0;
    cyc();
    check("drain_valid", {63'd0, ID_valid_o}, 64'd0);
    check("drain_pc_hold", ID_pc_o, 64'h100C);

    // Flush kills the held beat and discards the one on offer
    EX_ready_i = 1'b0;
    offer(64'h2000, 32'h0010_0113);
    cyc();
    check("flush_pre_valid", {63'd0, ID_valid_o}, 64'd1);
    offer(64'h3000, 32'h0020_0193);
    flush_i = 1'b1; redirect_pc_i = 64'h8000;
    #1;
    check("flush_pc_next", pc_next_o, 64'h8000);
    cyc();
    check("flush_valid", {63'd0, ID_valid_o}, 64'd0);
    check("flush_pc_hold", ID_pc_o, 64'h2000);
    flush_i = 1'b0; IF_valid_i = 1'b0; EX_ready_i = 1'b1;
    cyc();
    check("post_flush_valid", {63'd0, ID_valid_o}, 64'd0);

    // Illegal encodings and an addi to x0
    offer(64'h4000, 32'h0000_0000); exp_q.push_back(64'h4000);
    cyc();
    check("zero_illegal", {63'd0, ID_illegal_o}, 64'd1);
    check("zero_rf_wen", {63'd0, ID_rf_wen_o}, 64'd0);
    offer(64'h4004, 32'h0000_007F); exp_q.push_back(64'h4004);
    cyc();
    check("op7f_illegal", {63'd0, ID_illegal_o}, 64'd1);
    check("op7f_rf_wen", {63'd0, ID_rf_wen_o}, 64'd0);
    check("op7f_imm", ID_imm_o, 64'd0);
    offer(64'h4008, 32'h0050_0013); exp_q.push_back(64'h4008);
    cyc();
    check("addi_x0_rf_wen", {63'd0, ID_rf_wen_o}, 64'd0);
    check("addi_x0_illegal", {63'd0, ID_illegal_o}, 64'd0);
    check("addi_x0_imm", ID_imm_o, 64'd5);
    IF_valid_i = 1'b0;
    cyc();

    // PC wrap
    IF_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    check("pc_wrap", pc_next_o, 64'd0);

    // Reset while a beat is held
    EX_ready_i = 1'b0;
    offer(64'h5000, 32'h0070_0393);
    cyc();
    check("pre_rst_valid", {63'd0, ID_valid_o}, 64'd1);
    IF_valid_i = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; EX_ready_i = 1'b1;
    #1;
    check_reset_values("rst_held");
    cyc(); cyc();

    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
